// File: rtl/fpaddsub_norm_round_seq.sv
// Post-execution stage of the single-precision add/sub datapath.
// Normalizes one bit per cycle, rounds to nearest-even and packs the result behind valid/ready handshakes.
module fpaddsub_norm_round_seq #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MW+9:0]    Sum,
    input  logic             PSgn,
    input  logic             Opr,
    input  logic [EW-1:0]    Emax,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   Result,
    output logic             Overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [MW+9:0]  m_q, m_d;
    logic [EW:0]    e_q, e_d;
    logic           s_q, s_d;
    logic           z_q, z_d;
    logic [EW+MW:0] result_q, result_d;
    logic           overflow_q, overflow_d;

    logic           rnd_inc_s;
    logic [MW+1:0]  r25_s;
    logic [EW:0]    rnd_exp_s;
    logic [MW-1:0]  rnd_frac_s;
    logic [EW+MW:0] rnd_result_s;
    logic           rnd_ovf_s;

    // Effective operation does not steer this stage; a carry is always handled by the right shift.
    logic           opr_unused_s;
    assign opr_unused_s = Opr;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign Overflow  = overflow_q;

    // Round-to-nearest-even and packing of the normalized mantissa.
    always_comb begin
        rnd_inc_s  = m_q[7] & ((|m_q[6:0]) | m_q[8]);
        r25_s      = {1'b0, m_q[31:8]} + {24'd0, rnd_inc_s};
        rnd_frac_s = 23'd0;
        rnd_exp_s  = 9'd0;
        if (r25_s[24]) begin
            rnd_exp_s  = e_q + 9'd1;
            rnd_frac_s = 23'd0;
        end else begin
            rnd_frac_s = r25_s[22:0];
            rnd_exp_s  = r25_s[23] ? e_q : 9'd0;
        end
        if (z_q) begin
            rnd_result_s = 32'h0000_0000;
            rnd_ovf_s    = 1'b0;
        end else if (rnd_exp_s >= 9'd255) begin
            rnd_result_s = {s_q, 8'hFF, 23'd0};
            rnd_ovf_s    = 1'b1;
        end else begin
            rnd_result_s = {s_q, rnd_exp_s[7:0], rnd_frac_s};
            rnd_ovf_s    = 1'b0;
        end
    end

    // Next-state and datapath update for the capture/normalize/round/hold sequence.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        e_d        = e_q;
        s_d        = s_q;
        z_d        = z_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = Sum;
                    e_d     = {1'b0, Emax};
                    s_d     = PSgn & (Sum != 33'd0);
                    z_d     = (Sum == 33'd0);
                    state_d = NORM;
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                if (z_q) begin
                    state_d = ROUND;
                end else if (m_q[32]) begin
                    m_d     = {1'b0, m_q[32:2], m_q[1] | m_q[0]};
                    e_d     = e_q + 9'd1;
                    state_d = ROUND;
                end else if (m_q[31] || (e_q == 9'd1)) begin
                    state_d = ROUND;
                end else begin
                    m_d     = {m_q[31:0], 1'b0};
                    e_d     = e_q - 9'd1;
                    state_d = NORM;
                end
            end
            ROUND: begin
                e_d        = rnd_exp_s;
                result_d   = rnd_result_s;
                overflow_d = rnd_ovf_s;
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            m_q        <= 33'd0;
            e_q        <= 9'd0;
            s_q        <= 1'b0;
            z_q        <= 1'b0;
            result_q   <= 32'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            e_q        <= e_d;
            s_q        <= s_d;
            z_q        <= z_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fpaddsub_norm_round_seq.sv
// Bench for fpaddsub_norm_round_seq: directed vector table, corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_fpaddsub_norm_round_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:0] Sum = 33'd0;
    logic        PSgn = 1'b0;
    logic        Opr = 1'b0;
    logic [7:0]  Emax = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Result;
    logic        Overflow;

    int errors = 0;
    int checks = 0;

    fpaddsub_norm_round_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .Sum(Sum), .PSgn(PSgn), .Opr(Opr), .Emax(Emax),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] sum;
        logic        psgn;
        logic        opr;
        logic [7:0]  emax;
        logic [31:0] res;
        logic        ovf;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Value-level model: locate leading one, normalize within exponent limits, round half to even.
    function automatic void ref_model(input logic [32:0] sum, input logic psgn, input logic [7:0] emax,
                                      output logic [31:0] res, output logic ovf, output int lat);
        int     p;
        int     sh;
        int     ex;
        int     efield;
        longint mant;
        longint kept;
        longint rem;
        lat = 2;
        ovf = 1'b0;
        res = 32'd0;
        if (sum == 33'd0) return;
        p = 32;
        while (!sum[p]) p--;
        mant = longint'(sum);
        ex   = int'(emax);
        if (p == 32) begin
            mant = (mant >> 1) | (mant & 64'd1);
            ex   = ex + 1;
        end else begin
            sh = 31 - p;
            if (sh > ex - 1) sh = ex - 1;
            mant = mant << sh;
            ex   = ex - sh;
            lat  = lat + sh;
        end
        kept = mant >> 8;
        rem  = mant & 64'd255;
        if (rem > 128 || (rem == 128 && (kept % 2) == 1)) kept = kept + 1;
        if (kept == (longint'(1) << 24)) begin
            kept = longint'(1) << 23;
            ex   = ex + 1;
        end
        efield = (kept >= (longint'(1) << 23)) ? ex : 0;
        if (efield >= 255) begin
            res = {psgn, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else begin
            res = {psgn, efield[7:0], kept[22:0]};
        end
    endfunction

    // Issues one operation from an idle point (#1 after an edge) and checks latency, result and handoff.
    task automatic run_op(input logic [32:0] sum, input logic psgn, input logic opr, input logic [7:0] emax,
                          input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat, input string nm);
        int n;
        check({nm, " in_ready"}, {63'd0, in_ready}, 64'd1);
        Sum = sum; PSgn = psgn; Opr = opr; Emax = emax; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        Sum = 33'h1_2345_6789; PSgn = ~psgn; Emax = 8'd3;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, " latency"}, 64'(n), 64'(exp_lat));
        check({nm, " result"}, {32'd0, Result}, {32'd0, exp_res});
        check({nm, " overflow"}, {63'd0, Overflow}, {63'd0, exp_ovf});
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, " handoff"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] mres;
        logic        movf;
        int          mlat;
        logic [32:0] rsum;
        logic [32:0] mask;
        logic        ropr;
        logic        rsgn;
        logic [7:0]  remax;
        int          p;
        int          n;

        vecs[0] = '{33'h1_0000_0000, 1'b0, 1'b0, 8'd127, 32'h4000_0000, 1'b0, 2, "1p1"};
        vecs[1] = '{33'h0_4000_0000, 1'b0, 1'b1, 8'd127, 32'h3F00_0000, 1'b0, 3, "1p5m1"};
        vecs[2] = '{33'h0_8000_0180, 1'b0, 1'b0, 8'd127, 32'h3F80_0002, 1'b0, 2, "tie_odd"};
        vecs[3] = '{33'h0_8000_0080, 1'b0, 1'b0, 8'd127, 32'h3F80_0000, 1'b0, 2, "tie_even"};
        vecs[4] = '{33'h0_8000_0081, 1'b0, 1'b0, 8'd127, 32'h3F80_0001, 1'b0, 2, "above_tie"};
        vecs[5] = '{33'h0_FFFF_FF80, 1'b0, 1'b0, 8'd127, 32'h4000_0000, 1'b0, 2, "rnd_carry"};
        vecs[6] = '{33'h1_0000_0000, 1'b1, 1'b0, 8'd254, 32'hFF80_0000, 1'b1, 2, "ovf"};
        vecs[7] = '{33'h0_4000_0000, 1'b0, 1'b1, 8'd1,   32'h0040_0000, 1'b0, 2, "subnorm"};
        vecs[8] = '{33'h0_0000_0000, 1'b1, 1'b1, 8'd127, 32'h0000_0000, 1'b0, 2, "zero"};

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {63'd0, in_ready}, 64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset result", {32'd0, Result}, 64'd0);
        check("reset overflow", {63'd0, Overflow}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].sum, vecs[i].psgn, vecs[i].opr, vecs[i].emax,
                   vecs[i].res, vecs[i].ovf, vecs[i].lat, vecs[i].nm);
        end

        // Backpressure: result held for five cycles, new input refused.
        out_ready = 1'b0;
        Sum = 33'h1_0000_0000; PSgn = 1'b0; Opr = 1'b0; Emax = 8'd127; in_valid = 1'b1;
        @(posedge clk); #1;
        Sum = 33'h0_4000_0000; Emax = 8'd5;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp latency", 64'(n), 64'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp out_valid", {63'd0, out_valid}, 64'd1);
            check("bp result", {32'd0, Result}, 64'h4000_0000);
            check("bp in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", {62'd0, out_valid, in_ready}, 64'd1);
        @(posedge clk); #1;
        check("bp no capture", {62'd0, out_valid, in_ready}, 64'd1);

        // Reset in the middle of a normalization shift aborts the operation.
        Sum = 33'h0_4000_0000; PSgn = 1'b0; Opr = 1'b1; Emax = 8'd127; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid in_ready", {63'd0, in_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("abort in_ready", {63'd0, in_ready}, 64'd1);
        check("abort out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort still idle", {62'd0, out_valid, in_ready}, 64'd1);
        run_op(vecs[1].sum, vecs[1].psgn, vecs[1].opr, vecs[1].emax,
               vecs[1].res, vecs[1].ovf, vecs[1].lat, "post_reset");

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            p = $urandom_range(0, 32);
            mask = (33'd1 << p) - 33'd1;
            rsum = (33'd1 << p) | ({$urandom, $urandom} & {31'd0, mask});
            if ($urandom_range(0, 9) == 0) rsum = 33'd0;
            ropr = (p == 32) ? 1'b0 : 1'($urandom_range(0, 1));
            rsgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       remax = 8'($urandom_range(1, 8));
                1:       remax = 8'($urandom_range(248, 254));
                default: remax = 8'($urandom_range(1, 254));
            endcase
            ref_model(rsum, rsgn, remax, mres, movf, mlat);
            run_op(rsum, rsgn, ropr, remax, mres, movf, mlat, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
